// File: rtl/ps2_host_tx_if.sv
// Command/status and open-collector pin bundle between a PS/2 host transmitter and its user.
// The slave modport is the transmitter's view; master is the controller/pad side.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       ps2_clk_in;
  logic       ps2_data_in;
  logic       ps2_clk_oe;
  logic       ps2_data_oe;
  logic       rx_inhibit;
  logic       done;
  logic       ack_ok;
  logic       err_timeout;

  modport master (
    output tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    input  tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, done, ack_ok, err_timeout
  );

  modport slave (
    input  tx_data, tx_valid, ps2_clk_in, ps2_data_in,
    output tx_ready, ps2_clk_oe, ps2_data_oe, rx_inhibit, done, ack_ok, err_timeout
  );
endinterface

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibits the bus, requests to send, shifts a byte out on
// device clock falling edges, checks the device ack and aborts on a request-to-ack timeout.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_IDLE    | ready for a command byte, lines released
// S_INHIBIT | holding the clock low before the request
// S_REQ     | start bit driven, clock released on the next edge
// S_SHIFT   | presenting data, parity and stop on each device falling edge
// S_ACK     | waiting for the device ack falling edge
// S_WAITIDLE| waiting for clock and data to both return high
module ps2_host_tx #(
  parameter int INHIBIT_CYCLES = 2500,
  parameter int TIMEOUT_CYCLES = 375000,
  parameter int FILTER_LEN     = 8
) (
  input logic          clk,
  input logic          reset,
  ps2_host_tx_if.slave bus
);

  localparam int IW  = $clog2(INHIBIT_CYCLES + 1);
  localparam int TOW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int FW  = $clog2(FILTER_LEN + 1);

  localparam logic [IW-1:0]  INH_LOAD = IW'(INHIBIT_CYCLES - 2);
  localparam logic [TOW-1:0] TO_LOAD  = TOW'(TIMEOUT_CYCLES - 1);
  localparam logic [FW-1:0]  FLT_LAST = FW'(FILTER_LEN - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_INHIBIT, S_REQ, S_SHIFT, S_ACK, S_WAITIDLE
  } state_t;

  state_t         state, state_n;
  logic [1:0]     clk_s, dat_s;
  logic           clk_filt, fe;
  logic [FW-1:0]  flt_cnt;
  logic [IW-1:0]  inh_cnt, inh_cnt_n;
  logic [TOW-1:0] to_cnt, to_cnt_n;
  logic [3:0]     bit_cnt, bit_cnt_n;
  logic [7:0]     data_q, data_n;
  logic           par_q, par_n;
  logic           clk_oe_q, clk_oe_n, data_oe_q, data_oe_n;
  logic           ready_q, inhibit_q, done_q, done_n, ack_q, ack_n, err_q, err_n;
  logic           to_run, to_expired;

  // Synchronise both pins; the clock level only moves after FILTER_LEN agreeing samples
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      clk_s    <= 2'b11;
      dat_s    <= 2'b11;
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
      fe       <= 1'b0;
    end else begin
      clk_s <= {clk_s[0], bus.ps2_clk_in};
      dat_s <= {dat_s[0], bus.ps2_data_in};
      fe    <= 1'b0;
      if (clk_s[1] == clk_filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FLT_LAST) begin
        clk_filt <= clk_s[1];
        flt_cnt  <= '0;
        fe       <= clk_filt;
      end else begin
        flt_cnt <= flt_cnt + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      inh_cnt   <= '0;
      to_cnt    <= '0;
      bit_cnt   <= '0;
      data_q    <= '0;
      par_q     <= 1'b0;
      clk_oe_q  <= 1'b0;
      data_oe_q <= 1'b0;
      ready_q   <= 1'b1;
      inhibit_q <= 1'b0;
      done_q    <= 1'b0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state     <= state_n;
      inh_cnt   <= inh_cnt_n;
      to_cnt    <= to_cnt_n;
      bit_cnt   <= bit_cnt_n;
      data_q    <= data_n;
      par_q     <= par_n;
      clk_oe_q  <= clk_oe_n;
      data_oe_q <= data_oe_n;
      ready_q   <= (state_n == S_IDLE);
      inhibit_q <= (state_n != S_IDLE);
      done_q    <= done_n;
      ack_q     <= ack_n;
      err_q     <= err_n;
    end
  end

  always_comb begin
    state_n    = state;
    inh_cnt_n  = inh_cnt;
    to_cnt_n   = to_cnt;
    bit_cnt_n  = bit_cnt;
    data_n     = data_q;
    par_n      = par_q;
    clk_oe_n   = clk_oe_q;
    data_oe_n  = data_oe_q;
    done_n     = 1'b0;
    ack_n      = ack_q;
    err_n      = 1'b0;
    to_run     = (state == S_REQ) || (state == S_SHIFT) ||
                 (state == S_ACK) || (state == S_WAITIDLE);
    to_expired = to_run && (to_cnt == '0);

    if (to_run) to_cnt_n = to_cnt - 1'b1;

    // Expiry outranks a falling edge arriving on the same cycle
    if (to_expired) begin
      state_n   = S_IDLE;
      clk_oe_n  = 1'b0;
      data_oe_n = 1'b0;
      err_n     = 1'b1;
      to_cnt_n  = '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.tx_valid) begin
            data_n    = bus.tx_data;
            par_n     = ~^bus.tx_data;
            clk_oe_n  = 1'b1;
            inh_cnt_n = INH_LOAD;
            state_n   = S_INHIBIT;
          end
        end
        // The REQ cycle keeps the clock low, so INHIBIT itself lasts one cycle less
        S_INHIBIT: begin
          if (inh_cnt == '0) begin
            data_oe_n = 1'b1;
            to_cnt_n  = TO_LOAD;
            state_n   = S_REQ;
          end else begin
            inh_cnt_n = inh_cnt - 1'b1;
          end
        end
        S_REQ: begin
          clk_oe_n  = 1'b0;
          bit_cnt_n = '0;
          state_n   = S_SHIFT;
        end
        S_SHIFT: begin
          if (fe) begin
            bit_cnt_n = bit_cnt + 1'b1;
            if (bit_cnt < 4'd8) begin
              data_oe_n = ~data_q[bit_cnt[2:0]];
            end else if (bit_cnt == 4'd8) begin
              data_oe_n = ~par_q;
            end else begin
              data_oe_n = 1'b0;
              state_n   = S_ACK;
            end
          end
        end
        S_ACK: begin
          if (fe) begin
            ack_n   = ~dat_s[1];
            state_n = S_WAITIDLE;
          end
        end
        S_WAITIDLE: begin
          if (clk_filt && dat_s[1]) begin
            done_n  = 1'b1;
            state_n = S_IDLE;
          end
        end
        default: state_n = S_IDLE;
      endcase
    end
  end

  assign bus.tx_ready    = ready_q;
  assign bus.ps2_clk_oe  = clk_oe_q;
  assign bus.ps2_data_oe = data_oe_q;
  assign bus.rx_inhibit  = inhibit_q;
  assign bus.done        = done_q;
  assign bus.ack_ok      = ack_q;
  assign bus.err_timeout = err_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Directed bench for ps2_host_tx: a behavioural PS/2 device clocks frames out of the host
// and the observed bits, handshakes and timings are compared with hand-computed values.
module tb_ps2_host_tx;
  localparam int INH = 50;
  localparam int TO  = 3000;
  localparam int FL  = 8;
  localparam int H   = 40;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic dev_clk = 1'b1;
  logic dev_data = 1'b1;
  logic glitch = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   done_cnt = 0;
  int   tout_cnt = 0;
  logic last_ack = 1'b0;

  ps2_host_tx_if bus ();

  ps2_host_tx #(.INHIBIT_CYCLES(INH), .TIMEOUT_CYCLES(TO), .FILTER_LEN(FL)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  // Open-collector bus: either side can pull a line low
  assign bus.ps2_clk_in  = ~bus.ps2_clk_oe & dev_clk & ~glitch;
  assign bus.ps2_data_in = ~bus.ps2_data_oe & dev_data;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.done) begin
      done_cnt++;
      last_ack = bus.ack_ok;
    end
    if (bus.err_timeout) tout_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    chk("ready_before_send", bus.tx_ready, 1);
    bus.tx_data  = b;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
    bus.tx_data  = 8'h00;
    chk("ready_low_after_accept", bus.tx_ready, 0);
    chk("inhibit_flag", bus.rx_inhibit, 1);
  endtask

  // Count cycles with the clock held low; t_req is the cycle the start bit appeared
  task automatic inhibit_phase(output int t_req);
    int n = 0;
    int guard = 0;
    bit seen = 0;
    t_req = 0;
    while (bus.ps2_clk_oe !== 1'b1 && guard < 10) begin
      @(negedge clk);
      guard++;
    end
    while (bus.ps2_clk_oe === 1'b1 && n < 10 * INH) begin
      if (bus.ps2_data_oe === 1'b1 && !seen) begin
        seen  = 1;
        t_req = cyc;
      end
      n++;
      @(negedge clk);
    end
    chk("inhibit_len", n, INH);
    chk("start_bit_held", bus.ps2_data_oe, 1);
    chk("req_to_release", cyc - t_req, 1);
  endtask

  // got[0..7] data, got[8] parity, got[9] stop, sampled at each device clock rising edge
  task automatic dev_frame(input bit do_ack, input bit glitchy, input int npulses,
                           output logic [9:0] got);
    got = '0;
    repeat (H) @(negedge clk);
    for (int i = 1; i <= npulses; i++) begin
      if (i == 11 && do_ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      repeat (H) @(negedge clk);
      dev_clk = 1'b1;
      if (i <= 10) got[i-1] = bus.ps2_data_in;
      if (glitchy && i >= 2 && i <= 9) begin
        repeat (20) @(negedge clk);
        glitch = 1'b1;
        repeat (3) @(negedge clk);
        glitch = 1'b0;
        repeat (H - 23) @(negedge clk);
      end else begin
        repeat (H) @(negedge clk);
      end
      dev_data = 1'b1;
    end
  endtask

  task automatic finish_frame(input string tag, input int base, input logic exp_ack);
    int guard = 0;
    while (done_cnt == base && guard < 300) begin
      @(negedge clk);
      guard++;
    end
    repeat (3) @(negedge clk);
    chk({tag, "_done_once"}, done_cnt - base, 1);
    chk({tag, "_ack"}, last_ack, exp_ack);
    chk({tag, "_ready"}, bus.tx_ready, 1);
    chk({tag, "_lines"}, {bus.ps2_clk_oe, bus.ps2_data_oe, bus.rx_inhibit}, 0);
  endtask

  task automatic full_frame(input string tag, input logic [7:0] b, input bit do_ack,
                            input bit glitchy, input logic [9:0] exp_bits);
    int t_req;
    int base;
    logic [9:0] got;
    base = done_cnt;
    send(b);
    inhibit_phase(t_req);
    chk({tag, "_start"}, bus.ps2_data_in, 0);
    dev_frame(do_ack, glitchy, 11, got);
    chk({tag, "_bits"}, got, exp_bits);
    finish_frame(tag, base, do_ack);
  endtask

  initial begin
    int t_req;
    int base;
    int guard;
    logic [9:0] got;
    bus.tx_data  = 8'h00;
    bus.tx_valid = 1'b0;
    repeat (4) @(negedge clk);
    chk("rst_outputs", {bus.tx_ready, bus.ps2_clk_oe, bus.ps2_data_oe, bus.rx_inhibit,
                        bus.done, bus.ack_ok, bus.err_timeout}, 7'b1000000);
    reset = 1'b0;
    repeat (20) @(negedge clk);

    // 0xED: bits 1,0,1,1,0,1,1,1 parity 1 stop 1
    full_frame("ed", 8'hED, 1'b1, 1'b0, 10'h3ED);
    // 0x02: parity 0
    full_frame("02", 8'h02, 1'b1, 1'b0, 10'h202);

    // No device clock: timeout exactly TO cycles after the request
    base = done_cnt;
    send(8'h3C);
    inhibit_phase(t_req);
    guard = 0;
    while (bus.err_timeout !== 1'b1 && guard < TO + 100) begin
      @(negedge clk);
      guard++;
    end
    chk("to_latency", cyc - t_req, TO);
    chk("to_lines", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    @(negedge clk);
    chk("to_pulse_len", bus.err_timeout, 0);
    chk("to_ready", bus.tx_ready, 1);
    chk("to_no_done", done_cnt - base, 0);
    chk("to_count", tout_cnt, 1);
    repeat (20) @(negedge clk);

    // 0x55 with the device leaving data high: parity 1, no ack
    full_frame("nak", 8'h55, 1'b0, 1'b0, 10'h355);
    // 0xA5 with short clock glitches during the shift
    full_frame("glitch", 8'hA5, 1'b1, 1'b1, 10'h3A5);

    // Reset after the 5th falling edge: 0x00 keeps data pulled low for bit 4
    base = done_cnt;
    send(8'h00);
    inhibit_phase(t_req);
    dev_frame(1'b1, 1'b0, 4, got);
    dev_clk = 1'b0;
    repeat (20) @(negedge clk);
    chk("mid_data_oe", bus.ps2_data_oe, 1);
    chk("mid_inhibit", bus.rx_inhibit, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_oe", {bus.ps2_clk_oe, bus.ps2_data_oe}, 0);
    @(negedge clk);
    dev_clk = 1'b1;
    chk("rst_ready", bus.tx_ready, 1);
    chk("rst_inhibit", bus.rx_inhibit, 0);
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    chk("rst_no_done", done_cnt - base, 0);
    full_frame("ff", 8'hFF, 1'b1, 1'b0, 10'h3FF);
    chk("no_stray_timeout", tout_cnt, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
